// File: rtl/lfsr_stream_crypt.sv
// Streaming LFSR stream cipher: encrypts with host taps/seed, or recovers the key from a padded preamble and decrypts.
// One-cycle latency through a single output register; input is refused while that register holds an unaccepted byte.
module lfsr_stream_crypt #(
  parameter int LFSR_W = 7,
  parameter int MSG_LEN = 64,
  parameter int NUM_PTRN = 9,
  parameter logic [NUM_PTRN*7-1:0] PTRN_TABLE =
    {7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B},
  parameter logic [7:0] PAD_CHAR = 8'h20,
  parameter int TRAIN_LEN = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ack,
  input  logic              mode,
  input  logic [LFSR_W-1:0] taps,
  input  logic [LFSR_W-1:0] seed,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  output logic [LFSR_W-1:0] key_seed,
  output logic [3:0]        key_idx,
  output logic              key_fail,
  output logic [7:0]        par_err_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;

  logic              mode_q;
  logic [LFSR_W-1:0] taps_q;
  logic [LFSR_W-1:0] lfsr_q;
  logic [7:0]        count_q;
  logic [LFSR_W-1:0] cand_q   [NUM_PTRN];
  logic [LFSR_W-1:0] cand_nxt [NUM_PTRN];
  logic [NUM_PTRN-1:0] alive_q, alive_nxt, match;

  logic              accept, out_fire, training, fail_nxt, par_err;
  logic [3:0]        sel;
  logic [LFSR_W-1:0] pad_seed;
  logic [6:0]        enc_c;
  logic [7:0]        enc_byte, dec_byte, plain;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s,
                                                   input logic [LFSR_W-1:0] t);
    return {s[LFSR_W-2:0], ^(s & t)};
  endfunction

  assign ack      = (state_q == DONE);
  assign in_ready = (state_q == RUN) && (count_q < 8'(MSG_LEN)) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!start) state_d = RUN;
      RUN:     if (out_fire && count_q == 8'(MSG_LEN)) state_d = DONE;
      DONE:    if (start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every candidate runs in parallel; training prunes those that fail to reproduce the pad.
  always_comb begin
    pad_seed  = in_data[LFSR_W-1:0] ^ PAD_CHAR[LFSR_W-1:0];
    training  = (count_q < 8'(TRAIN_LEN));
    match     = '0;
    for (int k = 0; k < NUM_PTRN; k++) begin
      cand_nxt[k] = lfsr_step(cand_q[k], PTRN_TABLE[(NUM_PTRN-1-k)*7 +: LFSR_W]);
      match[k]    = ((in_data[6:0] ^ 7'(cand_nxt[k])) == PAD_CHAR[6:0]);
    end
    alive_nxt = training ? (alive_q & match) : alive_q;
    fail_nxt  = key_fail || (alive_nxt == '0);
    sel       = 4'd0;
    for (int k = NUM_PTRN-1; k >= 0; k--)
      if (alive_nxt[k]) sel = 4'(k);
    if (fail_nxt) sel = 4'd0;
    plain = {1'b0, in_data[6:0] ^ 7'(cand_nxt[sel])};
    if (count_q == 8'd0)   dec_byte = PAD_CHAR;
    else if (training)     dec_byte = fail_nxt ? plain : PAD_CHAR;
    else                   dec_byte = plain;
    enc_c    = in_data[6:0] ^ 7'(lfsr_q);
    enc_byte = {^enc_c, enc_c};
    par_err  = in_data[7] ^ (^in_data[6:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      taps_q      <= '0;
      lfsr_q      <= '0;
      count_q     <= 8'd0;
      alive_q     <= '0;
      for (int k = 0; k < NUM_PTRN; k++) cand_q[k] <= '0;
      out_valid   <= 1'b0;
      out_data    <= 8'd0;
      key_seed    <= '0;
      key_idx     <= 4'hF;
      key_fail    <= 1'b0;
      par_err_cnt <= 8'd0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && !start) begin
        mode_q      <= mode;
        taps_q      <= taps;
        lfsr_q      <= seed;
        count_q     <= 8'd0;
        par_err_cnt <= 8'd0;
        key_fail    <= 1'b0;
        key_idx     <= 4'hF;
        out_valid   <= 1'b0;
        if (!mode) key_seed <= seed;
      end else if (state_q == RUN) begin
        if (out_fire) out_valid <= 1'b0;
        if (accept) begin
          out_valid <= 1'b1;
          count_q   <= count_q + 8'd1;
          if (!mode_q) begin
            out_data <= enc_byte;
            lfsr_q   <= lfsr_step(lfsr_q, taps_q);
          end else begin
            out_data <= dec_byte;
            if (par_err && par_err_cnt != 8'hFF) par_err_cnt <= par_err_cnt + 8'd1;
            if (count_q == 8'd0) begin
              for (int k = 0; k < NUM_PTRN; k++) cand_q[k] <= pad_seed;
              alive_q  <= '1;
              key_seed <= pad_seed;
              key_fail <= (pad_seed == '0);
            end else begin
              for (int k = 0; k < NUM_PTRN; k++) cand_q[k] <= cand_nxt[k];
              alive_q  <= alive_nxt;
              key_fail <= fail_nxt;
              if (count_q == 8'(TRAIN_LEN-1)) key_idx <= sel;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lfsr_stream_crypt.sv
// Bench for lfsr_stream_crypt: directed and randomized runs checked against a keystream-array reference model.
module tb_lfsr_stream_crypt;
  localparam int MSG_LEN = 64, TRAIN_LEN = 10, NUM_PTRN = 9;

  logic clk = 1'b0, rst, start, mode, in_valid, in_ready, out_valid, out_ready, ack, key_fail;
  logic [6:0] taps, seed, key_seed;
  logic [7:0] in_data, out_data, par_err_cnt;
  logic [3:0] key_idx;

  lfsr_stream_crypt dut (
    .clk(clk), .rst(rst), .start(start), .ack(ack), .mode(mode), .taps(taps), .seed(seed),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .key_seed(key_seed), .key_idx(key_idx), .key_fail(key_fail), .par_err_cnt(par_err_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int ptrn[NUM_PTRN] = '{'h60, 'h48, 'h78, 'h72, 'h6A, 'h69, 'h5C, 'h7E, 'h7B};
  logic [7:0] plain[MSG_LEN], cipher[MSG_LEN], in_bytes[MSG_LEN], exp_bytes[MSG_LEN];
  logic [7:0] got[$];
  int stall_err, m_seed, m_idx, m_par;
  bit timed_out, m_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int step(input int s, input int t);
    return ((s << 1) & 'h7F) | ($countones(s & t) % 2);
  endfunction

  function automatic logic [31:0] got_at(input int i);
    return (i < got.size()) ? 32'(got[i]) : 32'hDEAD;
  endfunction

  // Keystream byte n is the seed advanced n times; bit 7 carries parity of the ciphertext payload.
  function automatic void enc_model(input int t, input int s0);
    int s = s0;
    for (int n = 0; n < MSG_LEN; n++) begin
      int c = (plain[n] & 'h7F) ^ s;
      cipher[n] = 8'(c | (($countones(c) % 2) << 7));
      s = step(s, t);
    end
  endfunction

  function automatic void dec_model();
    int ks[NUM_PTRN][MSG_LEN];
    bit alive[NUM_PTRN];
    int sd = (in_bytes[0] & 'h7F) ^ 'h20;
    bit fail = (sd == 0);
    int sel = 0;
    m_seed = sd;
    m_par = 0;
    for (int n = 0; n < MSG_LEN; n++)
      if (in_bytes[n][7] != ($countones(in_bytes[n] & 'h7F) % 2) && m_par < 255) m_par++;
    for (int k = 0; k < NUM_PTRN; k++) begin
      ks[k][0] = sd;
      alive[k] = 1'b1;
      for (int n = 1; n < MSG_LEN; n++) ks[k][n] = step(ks[k][n-1], ptrn[k]);
    end
    exp_bytes[0] = 8'h20;
    for (int n = 1; n < TRAIN_LEN; n++) begin
      bit any = 1'b0;
      for (int k = 0; k < NUM_PTRN; k++) begin
        if (((in_bytes[n] & 'h7F) ^ ks[k][n]) != 'h20) alive[k] = 1'b0;
        any |= alive[k];
      end
      if (!any) fail = 1'b1;
      exp_bytes[n] = fail ? 8'((in_bytes[n] & 'h7F) ^ ks[0][n]) : 8'h20;
    end
    if (!fail)
      for (int k = NUM_PTRN-1; k >= 0; k--) if (alive[k]) sel = k;
    m_idx = sel;
    m_fail = fail;
    for (int n = TRAIN_LEN; n < MSG_LEN; n++) exp_bytes[n] = 8'((in_bytes[n] & 'h7F) ^ ks[sel][n]);
  endfunction

  task automatic launch(input bit md, input logic [6:0] t, input logic [6:0] s, input bit hold_start);
    @(negedge clk);
    start = 1'b0; mode = md; taps = t; seed = s;
    @(posedge clk);
    #1;
    mode = ~md; taps = 7'($urandom); seed = 7'($urandom);
    if (hold_start) start = 1'b1;
  endtask

  task automatic run_stream(input bit stalls, input int abort_at);
    int in_idx = 0, cyc = 0, stall_left = 0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_dat = 8'h00;
    got.delete();
    stall_err = 0;
    timed_out = 1'b0;
    while (got.size() < MSG_LEN) begin
      @(negedge clk);
      if (abort_at >= 0 && in_idx == abort_at) break;
      if (cyc >= 2000) begin timed_out = 1'b1; break; end
      if (stalls && stall_left > 0) begin
        out_ready = 1'b0; stall_left--;
      end else begin
        out_ready = 1'b1;
        if (stalls && $urandom_range(0, 2) == 0) stall_left = $urandom_range(1, 5);
      end
      in_valid = (in_idx < MSG_LEN) && (!stalls || $urandom_range(0, 3) != 0);
      in_data  = in_valid ? in_bytes[in_idx] : 8'($urandom);
      #1;
      if (prev_stall && (!out_valid || out_data !== prev_dat)) stall_err++;
      if (out_valid && out_ready) got.push_back(out_data);
      if (in_valid && in_ready) in_idx++;
      prev_stall = out_valid && !out_ready;
      prev_dat = out_data;
      cyc++;
    end
  endtask

  task automatic finish_run(input string tag);
    check({tag, "_timeout"}, timed_out, 0);
    check({tag, "_count"}, got.size(), MSG_LEN);
    for (int i = 0; i < MSG_LEN; i++) check($sformatf("%s_b%0d", tag, i), got_at(i), exp_bytes[i]);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_ack"}, ack, 1);
    start = 1'b1;
    @(negedge clk);
    check({tag, "_ack_drop"}, ack, 0);
  endtask

  task automatic set_known_plain();
    string msg = "A joke is a very serious thing.";
    for (int i = 0; i < MSG_LEN; i++) plain[i] = 8'h20;
    for (int i = 0; i < msg.len(); i++) plain[13 + i] = msg[i];
  endtask

  task automatic gen_random_dec(input int pidx, input int s);
    int pre = $urandom_range(TRAIN_LEN, 15);
    for (int i = 0; i < MSG_LEN; i++) plain[i] = (i < pre) ? 8'h20 : 8'($urandom_range('h21, 'h7E));
    enc_model(ptrn[pidx], s);
    for (int i = 0; i < MSG_LEN; i++) in_bytes[i] = cipher[i];
    dec_model();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rs, rt;
    rst = 1'b1; start = 1'b1; mode = 1'b0; taps = '0; seed = '0;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    #12;
    check("rst_ack", ack, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_key_fail", key_fail, 0);
    check("rst_par", par_err_cnt, 0);
    check("rst_key_seed", key_seed, 0);
    check("rst_key_idx", key_idx, 4'hF);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 0);

    // Encrypt with the documented key; first two pad bytes have known ciphertext.
    for (int i = 0; i < MSG_LEN; i++) plain[i] = 8'($urandom);
    plain[0] = 8'h20; plain[1] = 8'h20;
    enc_model('h72, 'h3A);
    for (int i = 0; i < MSG_LEN; i++) begin in_bytes[i] = plain[i]; exp_bytes[i] = cipher[i]; end
    launch(1'b0, 7'h72, 7'h3A, 1'b0);
    run_stream(1'b0, -1);
    check("enc_first", got_at(0), 32'h9A);
    check("enc_second", got_at(1), 32'h55);
    finish_run("enc");
    check("enc_key_seed", key_seed, 7'h3A);
    check("enc_key_idx", key_idx, 4'hF);

    // Decrypt the known message.
    set_known_plain();
    enc_model(ptrn[3], 58);
    for (int i = 0; i < MSG_LEN; i++) in_bytes[i] = cipher[i];
    dec_model();
    launch(1'b1, 7'h00, 7'h00, 1'b0);
    run_stream(1'b0, -1);
    for (int i = 0; i < MSG_LEN; i++) check($sformatf("dec_plain_b%0d", i), got_at(i), plain[i]);
    finish_run("dec");
    check("dec_key_idx", key_idx, 3);
    check("dec_key_seed", key_seed, 7'h3A);
    check("dec_key_fail", key_fail, 0);
    check("dec_par", par_err_cnt, 0);

    // Parity bit flips on payload bytes.
    in_bytes[20] ^= 8'h80;
    in_bytes[40] ^= 8'h80;
    dec_model();
    launch(1'b1, 7'h00, 7'h00, 1'b0);
    run_stream(1'b0, -1);
    finish_run("par");
    check("par_cnt", par_err_cnt, 2);
    check("par_key_idx", key_idx, 3);

    // Corrupted training byte kills every candidate.
    for (int i = 0; i < MSG_LEN; i++) in_bytes[i] = cipher[i];
    in_bytes[5] ^= 8'h01;
    dec_model();
    launch(1'b1, 7'h00, 7'h00, 1'b0);
    run_stream(1'b0, -1);
    check("kf_b5_not_pad", got_at(5) == 32'h20, 0);
    finish_run("kf");
    check("kf_key_fail", key_fail, 1);
    check("kf_key_fail_model", key_fail, m_fail);

    // Backpressure with Start raised mid-run.
    for (int i = 0; i < MSG_LEN; i++) in_bytes[i] = cipher[i];
    dec_model();
    launch(1'b1, 7'h00, 7'h00, 1'b1);
    run_stream(1'b1, -1);
    check("stall_stable", stall_err, 0);
    finish_run("stall");
    check("stall_key_idx", key_idx, 3);

    // Reset mid-run after a parity error has been counted.
    in_bytes[20] ^= 8'h80;
    launch(1'b1, 7'h00, 7'h00, 1'b0);
    run_stream(1'b0, 30);
    check("abort_par_pre", par_err_cnt, 1);
    in_valid = 1'b0; start = 1'b1; rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", out_data, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_par", par_err_cnt, 0);
    check("abort_key_idx", key_idx, 4'hF);
    check("abort_key_seed", key_seed, 0);
    @(negedge clk);
    rst = 1'b0;
    rs = $urandom_range(1, 127);
    rt = $urandom_range(0, NUM_PTRN-1);
    gen_random_dec(rt, rs);
    launch(1'b1, 7'h00, 7'h00, 1'b0);
    run_stream(1'b0, -1);
    finish_run("rdec");
    check("rdec_par", par_err_cnt, m_par);
    check("rdec_key_seed", key_seed, m_seed);
    check("rdec_key_idx", key_idx, m_idx);
    check("rdec_key_fail", key_fail, m_fail);

    // Random key encrypt under backpressure.
    rs = $urandom_range(1, 127);
    rt = $urandom_range(1, 127);
    for (int i = 0; i < MSG_LEN; i++) plain[i] = 8'($urandom);
    enc_model(rt, rs);
    for (int i = 0; i < MSG_LEN; i++) begin in_bytes[i] = plain[i]; exp_bytes[i] = cipher[i]; end
    launch(1'b0, 7'(rt), 7'(rs), 1'b0);
    run_stream(1'b1, -1);
    check("renc_stable", stall_err, 0);
    finish_run("renc");
    check("renc_key_seed", key_seed, 7'(rs));
    check("renc_key_idx", key_idx, 4'hF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lfsr_stream_crypt.md
Name: lfsr_stream_crypt

Overview:
- Hardware successor to the software encrypt/decrypt programs: a streaming LFSR stream-cipher engine with parity.
- Sits beside the processor data path. Bytes arrive and leave on valid/ready streams, not through data memory.
- Encrypt mode: a host-supplied tap pattern and seed are applied to each byte.
- Decrypt mode: the engine recovers the seed and tap pattern from the space-padded preamble, then decrypts the rest of the message on the fly.

Parameters:
- LFSR_W, 7: LFSR width. Legal range 2..7; it XORs into payload bits [LFSR_W-1:0].
- MSG_LEN, 64: bytes per run, 1..255.
- NUM_PTRN, 9: number of candidate tap patterns.
- PTRN_TABLE, {7'h60,7'h48,7'h78,7'h72,7'h6A,7'h69,7'h5C,7'h7E,7'h7B}: candidate taps. Index 0 is the leftmost entry.
- PAD_CHAR, 8'h20: preamble character.
- TRAIN_LEN, 10: preamble bytes used for key recovery, 2..MSG_LEN.

Ports:
- Clk, in, 1: clock, rising edge.
- Reset, in, 1: asynchronous, active-high reset.
- Start, in, 1: high holds the engine idle; low launches a run.
- Ack, out, 1: run complete.
- Mode, in, 1: 0 = encrypt, 1 = decrypt. Sampled at launch.
- Taps, in, LFSR_W: encrypt tap pattern. Sampled at launch.
- Seed, in, LFSR_W: encrypt start state, nonzero. Sampled at launch.
- InValid, in, 1: input byte valid.
- InData, in, 8: input byte.
- InReady, out, 1: engine accepts the input byte.
- OutValid, out, 1: output byte valid.
- OutData, out, 8: output byte.
- OutReady, in, 1: sink accepts the output byte.
- KeySeed, out, LFSR_W: recovered seed (decrypt) or latched Seed (encrypt).
- KeyIdx, out, 4: recovered pattern index. 4'hF in encrypt mode.
- KeyFail, out, 1: no candidate survived training.
- ParErrCnt, out, 8: decrypt parity mismatches, saturating at 8'hFF.

Behaviour:
- Reset (async) values:
  - FSM goes to IDLE.
  - Ack, InReady, OutValid, KeyFail = 0.
  - OutData, ParErrCnt, byte count = 0.
  - KeySeed = 0; KeyIdx = 4'hF.
- LFSR step: next = {s[LFSR_W-2:0], ^(s & taps)}. The state advances once per accepted input byte.
- Mode, Taps and Seed are ignored outside the launch cycle.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on the first clock with Start=0. At that edge:
    - latch Mode, Taps and Seed;
    - clear the count, ParErrCnt and KeyFail;
    - in encrypt mode, KeySeed = Seed.
  - RUN -> DONE when the MSG_LEN-th output byte is accepted (OutValid & OutReady). Ack = 1 from the next cycle.
  - DONE -> IDLE when Start=1. Ack drops in the same cycle. Key outputs hold their values until the next launch.
- Handshake:
  - InReady = RUN & (count < MSG_LEN) & (!OutValid | OutReady).
  - One byte is transferred per cycle at most, through a single output register.
  - Latency is 1 cycle: a byte accepted at edge N appears on OutData after edge N.
  - OutData is held stable while OutValid & !OutReady.
- Encrypt, per byte p with state s:
  - c[6:0] = p[6:0] ^ zero-extended s.
  - c[7] = ^c[6:0]; p[7] is ignored.
- Decrypt, byte 0:
  - Every candidate k gets seed = InData[LFSR_W-1:0] ^ PAD_CHAR[LFSR_W-1:0].
  - All candidates start alive.
  - Output = PAD_CHAR.
  - KeySeed is latched from this seed.
  - A zero seed sets KeyFail immediately.
- Decrypt, bytes 1..TRAIN_LEN-1:
  - Each candidate steps its own LFSR with PTRN_TABLE[k] (truncated to LFSR_W).
  - Candidate k stays alive iff InData[6:0] ^ s_k == PAD_CHAR[6:0].
  - Output = PAD_CHAR if any candidate is alive after this byte.
  - If none is alive: KeyFail = 1 (sticky for the run), and this and all later bytes decrypt with candidate 0.
- Decrypt, from byte TRAIN_LEN on:
  - Use the lowest-index alive candidate. KeyIdx is set to it once byte TRAIN_LEN-1 is accepted.
  - OutData = {1'b0, InData[6:0] ^ s_sel}.
- Parity check, every decrypt byte including training bytes: InData[7] != ^InData[6:0] increments ParErrCnt. Decryption continues.
- Boundaries:
  - OutReady held low: InReady = 0, and no state, count or LFSR advances.
  - Start=1 during RUN is ignored.
  - Reset mid-run aborts immediately; any partial output is discarded.
  - MSG_LEN < TRAIN_LEN is illegal.

Test Plan:
- Encrypt with Taps=7'h72, Seed=7'h3A, input 0x20,0x20 -> 0x9A then 0x55; KeySeed=0x3A; Ack after 64 bytes.
- Decrypt the full 64-byte ciphertext of pattern 3, seed 58, pre_length 13, message "A joke is a very serious thing." -> plaintext matches byte-for-byte; KeyIdx=3; KeySeed=0x3A; KeyFail=0; ParErrCnt=0.
- Same decrypt stream with the bit-7 of bytes 20 and 40 flipped -> plaintext unchanged; ParErrCnt=2.
- Decrypt stream with byte 5 corrupted in payload bits -> KeyFail=1; byte 5 output is not PAD_CHAR.
- OutReady toggled randomly, with 1-5 stall cycles -> output sequence identical to the no-stall run; no bytes dropped or duplicated; OutData stable while stalled.
- Reset asserted at byte 30, then Start 1->0 with a new stream -> all outputs at reset values immediately; the second run completes correctly with ParErrCnt cleared.
